cus19_store_buffer: RTL and testbench

- Parametrised write-buffered successor to the single-cycle store path.
- Accepts store requests from the execute stage (address, byte data), queues them in a circular FIFO, and drains them to data memory over a req/ack handshake.
- Provides store-to-load forwarding for pending stores.
- Raises a stall to the pipeline when the queue is full.

---
 rtl/cus19_store_buffer.sv | 89 ++++++++
 tb/tb_cus19_store_buffer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cus19_store_buffer.sv
// cus19_store_buffer: circular store queue draining to data memory over req/ack, with store-to-load forwarding
module cus19_store_buffer #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_wr_in,
  input  logic [ADDR_W-1:0] imm_addr_in,
  input  logic [DATA_W-1:0] rs1_data_in,
  output logic              stall_out,
  output logic [ADDR_W-1:0] dm_wr_addr_out,
  output logic [DATA_W-1:0] dm_wr_data_out,
  output logic              dm_write_req,
  input  logic              dm_write_ack_in,
  input  logic [ADDR_W-1:0] ld_addr_in,
  output logic              ld_hit_out,
  output logic [DATA_W-1:0] ld_data_out,
  output logic [CNT_W-1:0]  count_out,
  output logic              empty_out
);
  localparam int PTR_W = $clog2(DEPTH);
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full, empty, push, pop;
  // Occupancy flags come from the registered count; a same-cycle ack never frees space for this cycle's push.
  always_comb begin
    full  = count_q == CNT_W'(DEPTH);
    empty = count_q == '0;
    push  = mem_wr_in && !full;
    pop   = !empty && dm_write_ack_in;
  end
  // Next-state pointers, count and valid bits; push and pop never target the same slot in one cycle.
  always_comb begin
    head_d  = pop ? head_q + 1'b1 : head_q;
    tail_d  = push ? tail_q + 1'b1 : tail_q;
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    valid_d = valid_q;
    if (pop) valid_d[head_q] = 1'b0;
    if (push) valid_d[tail_q] = 1'b1;
  end
  // State registers; reset discards every pending entry so nothing drains afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      if (push) begin
        addr_q[tail_q] <= imm_addr_in;
        data_q[tail_q] <= rs1_data_in;
      end
    end
  end
  // Drain port and status outputs; the head entry is held on the bus until acknowledged.
  always_comb begin
    stall_out      = full;
    empty_out      = empty;
    count_out      = count_q;
    dm_write_req   = !empty;
    dm_wr_addr_out = empty ? '0 : addr_q[head_q];
    dm_wr_data_out = empty ? '0 : data_q[head_q];
  end
  // Forwarding scans oldest to youngest so the youngest matching store wins; the incoming store is not visible yet.
  always_comb begin
    ld_hit_out  = 1'b0;
    ld_data_out = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (valid_q[PTR_W'(head_q + PTR_W'(k))] && addr_q[PTR_W'(head_q + PTR_W'(k))] == ld_addr_in) begin
        ld_hit_out  = 1'b1;
        ld_data_out = data_q[PTR_W'(head_q + PTR_W'(k))];
      end
    end
  end
endmodule

// File: tb/tb_cus19_store_buffer.sv
// tb_cus19_store_buffer: directed and randomized checks of the store buffer against a queue-based model
module tb_cus19_store_buffer;
  localparam int ADDR_W = 11;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 3;
  logic              clk = 0;
  logic              rst = 1;
  logic              mem_wr_in = 0;
  logic [ADDR_W-1:0] imm_addr_in = '0;
  logic [DATA_W-1:0] rs1_data_in = '0;
  logic              stall_out;
  logic [ADDR_W-1:0] dm_wr_addr_out;
  logic [DATA_W-1:0] dm_wr_data_out;
  logic              dm_write_req;
  logic              dm_write_ack_in = 0;
  logic [ADDR_W-1:0] ld_addr_in = '0;
  logic              ld_hit_out;
  logic [DATA_W-1:0] ld_data_out;
  logic [CNT_W-1:0]  count_out;
  logic              empty_out;
  int passed = 0;
  int total = 0;
  logic [ADDR_W+DATA_W-1:0] q[$];
  logic [ADDR_W+DATA_W-1:0] wlog[$];

  cus19_store_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .mem_wr_in(mem_wr_in), .imm_addr_in(imm_addr_in), .rs1_data_in(rs1_data_in),
    .stall_out(stall_out), .dm_wr_addr_out(dm_wr_addr_out), .dm_wr_data_out(dm_wr_data_out),
    .dm_write_req(dm_write_req), .dm_write_ack_in(dm_write_ack_in), .ld_addr_in(ld_addr_in),
    .ld_hit_out(ld_hit_out), .ld_data_out(ld_data_out), .count_out(count_out), .empty_out(empty_out)
  );

  always #5 clk = ~clk;

  function automatic logic m_hit(logic [ADDR_W-1:0] a);
    m_hit = 1'b0;
    foreach (q[i]) if (q[i][ADDR_W+DATA_W-1:DATA_W] == a) m_hit = 1'b1;
  endfunction

  function automatic logic [DATA_W-1:0] m_data(logic [ADDR_W-1:0] a);
    m_data = '0;
    foreach (q[i]) if (q[i][ADDR_W+DATA_W-1:DATA_W] == a) m_data = q[i][DATA_W-1:0];
  endfunction

  task automatic tick();
    logic full;
    full = q.size() == DEPTH;
    if (dm_write_req && dm_write_ack_in) wlog.push_back({dm_wr_addr_out, dm_wr_data_out});
    if (q.size() != 0 && dm_write_ack_in) void'(q.pop_front());
    if (mem_wr_in && !full) q.push_back({imm_addr_in, rs1_data_in});
    @(posedge clk);
    #1;
  endtask

  task automatic store(logic [ADDR_W-1:0] a, logic [DATA_W-1:0] d);
    mem_wr_in = 1; imm_addr_in = a; rs1_data_in = d;
    tick();
    mem_wr_in = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({stall_out, dm_write_req, dm_wr_addr_out, dm_wr_data_out, ld_hit_out, ld_data_out, count_out, empty_out} !== {1'b0, 1'b0, 11'h0, 8'h0, 1'b0, 8'h0, 3'd0, 1'b1})
      $display("FAIL reset_outputs got req=%b cnt=%0d empty=%b stall=%b", dm_write_req, count_out, empty_out, stall_out);
    else passed++;
    rst = 0;
    q.delete();
    tick();
    total++;
    if (dm_write_req !== 1'b0 || empty_out !== 1'b1) $display("FAIL reset_release got req=%b empty=%b exp 0/1", dm_write_req, empty_out);
    else passed++;
  endtask

  task automatic test_single();
    store(11'h1A3, 8'h5C);
    total++;
    if ({dm_write_req, dm_wr_addr_out, dm_wr_data_out, count_out} !== {1'b1, 11'h1A3, 8'h5C, 3'd1})
      $display("FAIL single_req got req=%b addr=%h data=%h cnt=%0d exp 1/1a3/5c/1", dm_write_req, dm_wr_addr_out, dm_wr_data_out, count_out);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({dm_write_req, dm_wr_addr_out, dm_wr_data_out} !== {1'b1, 11'h1A3, 8'h5C})
        $display("FAIL single_hold got req=%b addr=%h data=%h exp 1/1a3/5c", dm_write_req, dm_wr_addr_out, dm_wr_data_out);
      else passed++;
    end
    dm_write_ack_in = 1;
    tick();
    dm_write_ack_in = 0;
    total++;
    if (dm_write_req !== 1'b0 || empty_out !== 1'b1) $display("FAIL single_ack got req=%b empty=%b exp 0/1", dm_write_req, empty_out);
    else passed++;
  endtask

  task automatic test_fill();
    logic [ADDR_W-1:0] ea [5];
    logic [DATA_W-1:0] ed [5];
    ea = '{11'h010, 11'h011, 11'h012, 11'h013, 11'h3F4};
    ed = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hAA};
    for (int i = 0; i < 4; i++) store(ea[i], ed[i]);
    total++;
    if (stall_out !== 1'b1 || count_out !== 3'd4) $display("FAIL fill_full got stall=%b cnt=%0d exp 1/4", stall_out, count_out);
    else passed++;
    mem_wr_in = 1; imm_addr_in = 11'h3F4; rs1_data_in = 8'hAA;
    tick();
    total++;
    if (count_out !== 3'd4 || dm_wr_addr_out !== 11'h010) $display("FAIL fill_held got cnt=%0d head=%h exp 4/010", count_out, dm_wr_addr_out);
    else passed++;
    dm_write_ack_in = 1;
    tick();
    dm_write_ack_in = 0;
    total++;
    if (stall_out !== 1'b0 || count_out !== 3'd3) $display("FAIL fill_ack_no_push got stall=%b cnt=%0d exp 0/3", stall_out, count_out);
    else passed++;
    tick();
    mem_wr_in = 0;
    total++;
    if (count_out !== 3'd4) $display("FAIL fill_fifth_in got cnt=%0d exp 4", count_out);
    else passed++;
    for (int i = 1; i < 5; i++) begin
      total++;
      if (dm_wr_addr_out !== ea[i] || dm_wr_data_out !== ed[i])
        $display("FAIL fill_order[%0d] got %h/%h exp %h/%h", i, dm_wr_addr_out, dm_wr_data_out, ea[i], ed[i]);
      else passed++;
      dm_write_ack_in = 1;
      tick();
      dm_write_ack_in = 0;
    end
    total++;
    if (empty_out !== 1'b1) $display("FAIL fill_empty got %b exp 1", empty_out);
    else passed++;
  endtask

  task automatic test_forward();
    store(11'h07F, 8'h11);
    store(11'h07F, 8'hFF);
    ld_addr_in = 11'h07F;
    #1;
    total++;
    if (ld_hit_out !== 1'b1 || ld_data_out !== 8'hFF) $display("FAIL fwd_youngest got %b/%h exp 1/ff", ld_hit_out, ld_data_out);
    else passed++;
    ld_addr_in = 11'h080;
    mem_wr_in = 1; imm_addr_in = 11'h080; rs1_data_in = 8'h33;
    #1;
    total++;
    if (ld_hit_out !== 1'b0 || ld_data_out !== 8'h00) $display("FAIL fwd_miss got %b/%h exp 0/00", ld_hit_out, ld_data_out);
    else passed++;
    mem_wr_in = 0;
    dm_write_ack_in = 1;
    tick();
    ld_addr_in = 11'h07F;
    #1;
    total++;
    if (ld_hit_out !== 1'b1 || ld_data_out !== 8'hFF) $display("FAIL fwd_acked_entry got %b/%h exp 1/ff", ld_hit_out, ld_data_out);
    else passed++;
    tick();
    dm_write_ack_in = 0;
    #1;
    total++;
    if (ld_hit_out !== 1'b0 || empty_out !== 1'b1) $display("FAIL fwd_after_drain got hit=%b empty=%b exp 0/1", ld_hit_out, empty_out);
    else passed++;
  endtask

  task automatic test_simul();
    store(11'h100, 8'h01);
    store(11'h101, 8'h02);
    mem_wr_in = 1; imm_addr_in = 11'h102; rs1_data_in = 8'h03; dm_write_ack_in = 1;
    tick();
    mem_wr_in = 0;
    total++;
    if (count_out !== 3'd2 || dm_wr_addr_out !== 11'h101) $display("FAIL simul got cnt=%0d head=%h exp 2/101", count_out, dm_wr_addr_out);
    else passed++;
    tick();
    total++;
    if (dm_wr_addr_out !== 11'h102 || dm_wr_data_out !== 8'h03) $display("FAIL simul_tail got %h/%h exp 102/03", dm_wr_addr_out, dm_wr_data_out);
    else passed++;
    tick();
    dm_write_ack_in = 0;
  endtask

  task automatic test_wrap();
    int maxc = 0;
    wlog.delete();
    dm_write_ack_in = 1;
    for (int i = 0; i < 10; i++) begin
      mem_wr_in = 1; imm_addr_in = ADDR_W'(11'h200 + i); rs1_data_in = DATA_W'(i * 7 + 3);
      tick();
      if (int'(count_out) > maxc) maxc = int'(count_out);
    end
    mem_wr_in = 0;
    for (int i = 0; i < 10 && !empty_out; i++) tick();
    dm_write_ack_in = 0;
    total++;
    if (maxc > 2) $display("FAIL wrap_max_count got %0d exp <=2", maxc);
    else passed++;
    total++;
    if (wlog.size() != 10) $display("FAIL wrap_write_count got %0d exp 10", wlog.size());
    else passed++;
    for (int i = 0; i < 10 && i < wlog.size(); i++) begin
      total++;
      if (wlog[i] !== {ADDR_W'(11'h200 + i), DATA_W'(i * 7 + 3)}) $display("FAIL wrap_write[%0d] got %h exp %h", i, wlog[i], {ADDR_W'(11'h200 + i), DATA_W'(i * 7 + 3)});
      else passed++;
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      mem_wr_in = ($urandom_range(0, 9) < 6);
      imm_addr_in = ADDR_W'(11'h3F0 + $urandom_range(0, 3));
      rs1_data_in = DATA_W'($urandom);
      dm_write_ack_in = $urandom_range(0, 1) == 1;
      ld_addr_in = ADDR_W'(11'h3F0 + $urandom_range(0, 4));
      #1;
      total++;
      if (count_out !== CNT_W'(q.size()) || stall_out !== (q.size() == DEPTH) || empty_out !== (q.size() == 0) || dm_write_req !== (q.size() != 0))
        $display("FAIL rand_status[%0d] got cnt=%0d stall=%b empty=%b req=%b exp cnt=%0d", n, count_out, stall_out, empty_out, dm_write_req, q.size());
      else passed++;
      total++;
      if ({dm_wr_addr_out, dm_wr_data_out} !== (q.size() != 0 ? q[0] : '0)) $display("FAIL rand_head[%0d] got %h/%h", n, dm_wr_addr_out, dm_wr_data_out);
      else passed++;
      total++;
      if (ld_hit_out !== m_hit(ld_addr_in) || ld_data_out !== m_data(ld_addr_in))
        $display("FAIL rand_fwd[%0d] got %b/%h exp %b/%h", n, ld_hit_out, ld_data_out, m_hit(ld_addr_in), m_data(ld_addr_in));
      else passed++;
      tick();
    end
    mem_wr_in = 0;
    dm_write_ack_in = 1;
    for (int i = 0; i < 8 && !empty_out; i++) tick();
    dm_write_ack_in = 0;
    q.delete();
  endtask

  task automatic test_reset_mid();
    store(11'h050, 8'h50);
    store(11'h051, 8'h51);
    store(11'h052, 8'h52);
    total++;
    if (count_out !== 3'd3 || dm_write_req !== 1'b1) $display("FAIL mid_setup got cnt=%0d req=%b exp 3/1", count_out, dm_write_req);
    else passed++;
    #2;
    rst = 1;
    #1;
    total++;
    if ({stall_out, dm_write_req, dm_wr_addr_out, dm_wr_data_out, ld_hit_out, ld_data_out, count_out, empty_out} !== {1'b0, 1'b0, 11'h0, 8'h0, 1'b0, 8'h0, 3'd0, 1'b1})
      $display("FAIL mid_async_reset got req=%b cnt=%0d empty=%b addr=%h", dm_write_req, count_out, empty_out, dm_wr_addr_out);
    else passed++;
    q.delete();
    dm_write_ack_in = 1;
    @(posedge clk);
    #1;
    rst = 0;
    wlog.delete();
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (dm_write_req !== 1'b0) $display("FAIL mid_no_write[%0d] got req=%b exp 0", i, dm_write_req);
      else passed++;
    end
    total++;
    if (wlog.size() != 0) $display("FAIL mid_write_log got %0d writes exp 0", wlog.size());
    else passed++;
    dm_write_ack_in = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_forward();
    test_simul();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
